// File: rtl/seq_lock_pkg.sv
// Shared types and constants for the seq_lock keypad lock: state encoding,
// code geometry and the width of the shared down-counting timer.
package seq_lock_pkg;

  localparam int DIGIT_W  = 2;
  localparam int CODE_LEN = 4;
  localparam int TIMER_W  = 24;
  localparam int CODE_W   = DIGIT_W * CODE_LEN;
  localparam int CNT_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_OPEN,
    ST_LOCKOUT
  } state_e;

  typedef logic [DIGIT_W-1:0] digit_t;
  typedef logic [CNT_W-1:0]   cnt_t;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == '1) ? v : v + cnt_t'(1);
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Shared down-counting hold timer for seq_lock. A load of N raises expired
// on the Nth cycle after the load edge; expiry disarms the timer.
module lock_timer
  import seq_lock_pkg::*;
(
  input  logic               sysclk,
  input  logic               reset_n,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic               expired
);

  logic [TIMER_W-1:0] count;
  logic               armed;

  // The load cycle counts as the first held cycle, so N-1 is stored.
  // NOTE: sequential state is written with non-blocking assignments only;
  // combinational blocks use blocking assignments.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      armed <= 1'b0;
    end else if (load) begin
      count <= (load_val == '0) ? '0 : load_val - TIMER_W'(1);
      armed <= 1'b1;
    end else if (armed) begin
      if (count == '0) begin
        armed <= 1'b0;
      end else begin
        count <= count - TIMER_W'(1);
      end
    end
  end

  assign expired = armed && (count == '0);

endmodule

// File: rtl/seq_lock.sv
// Four-digit sequence lock: collects debounced key presses, opens on the right
// code and counts failures. Macro SEQ_LOCK_LOCKOUT_EN adds a timed lockout state.
module seq_lock
  import seq_lock_pkg::*;
#(
  parameter logic [CODE_W-1:0]  CODE        = 8'b01_11_00_10,
  parameter logic [TIMER_W-1:0] TIMEOUT_CYC = 24'd10_000_000,
  parameter logic [TIMER_W-1:0] UNLOCK_CYC  = 24'd5_000_000,
  parameter logic [TIMER_W-1:0] LOCKOUT_CYC = 24'd15_000_000,
  parameter int                 MAX_FAIL    = 3
) (
  input  logic             sysclk,
  input  logic             reset_n,
  input  logic             X0_deb,
  input  logic             X1_deb,
  input  logic             X2_deb,
  input  logic             X3_deb,
  output logic             unlocked,
  output logic             error,
  output logic             locked_out,
  output logic [CNT_W-1:0] digit_cnt,
  output logic [CNT_W-1:0] fail_cnt
);

  state_e             state, state_d;
  logic               mismatch, mismatch_d;
  cnt_t               digit_cnt_d, fail_cnt_d;
  logic               error_d, unlocked_d;
  logic               press;
  digit_t             press_digit;
  logic               digit_bad;
  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_val;
  logic               tmr_expired;

  lock_timer u_timer (
    .sysclk   (sysclk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  // Exactly one key high is a press; chords and idle are ignored alike.
  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block can infer a latch.
  always_comb begin
    press       = 1'b0;
    press_digit = '0;
    case ({X3_deb, X2_deb, X1_deb, X0_deb})
      4'b0001: begin press = 1'b1; press_digit = 2'd0; end
      4'b0010: begin press = 1'b1; press_digit = 2'd1; end
      4'b0100: begin press = 1'b1; press_digit = 2'd2; end
      4'b1000: begin press = 1'b1; press_digit = 2'd3; end
      default: begin press = 1'b0; press_digit = '0;   end
    endcase
  end

  // digit_cnt doubles as the index of the code digit expected next.
  assign digit_bad = (press_digit != CODE[DIGIT_W*digit_cnt[1:0] +: DIGIT_W]);

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      mismatch  <= 1'b0;
      digit_cnt <= '0;
      fail_cnt  <= '0;
      unlocked  <= 1'b0;
      error     <= 1'b0;
    end else begin
      state     <= state_d;
      mismatch  <= mismatch_d;
      digit_cnt <= digit_cnt_d;
      fail_cnt  <= fail_cnt_d;
      unlocked  <= unlocked_d;
      error     <= error_d;
    end
  end

  always_comb begin
    state_d     = state;
    mismatch_d  = mismatch;
    digit_cnt_d = digit_cnt;
    fail_cnt_d  = fail_cnt;
    error_d     = 1'b0;
    tmr_load    = 1'b0;
    tmr_val     = TIMEOUT_CYC;
    case (state)
      ST_IDLE: begin
        if (press) begin
          mismatch_d  = digit_bad;
          digit_cnt_d = cnt_t'(1);
          tmr_load    = 1'b1;
          tmr_val     = TIMEOUT_CYC;
          state_d     = ST_ENTRY;
        end
      end
      ST_ENTRY: begin
        // A press in the expiry cycle is still taken: press has priority.
        if (press) begin
          if (digit_cnt == cnt_t'(CODE_LEN - 1)) begin
            mismatch_d = 1'b0;
            if (mismatch || digit_bad) begin
              error_d     = 1'b1;
              fail_cnt_d  = sat_inc(fail_cnt);
              digit_cnt_d = '0;
              state_d     = ST_IDLE;
`ifdef SEQ_LOCK_LOCKOUT_EN
              if (int'(fail_cnt_d) >= MAX_FAIL) begin
                state_d  = ST_LOCKOUT;
                tmr_load = 1'b1;
                tmr_val  = LOCKOUT_CYC;
              end
`endif
            end else begin
              fail_cnt_d  = '0;
              digit_cnt_d = cnt_t'(CODE_LEN);
              tmr_load    = 1'b1;
              tmr_val     = UNLOCK_CYC;
              state_d     = ST_OPEN;
            end
          end else begin
            mismatch_d  = mismatch || digit_bad;
            digit_cnt_d = digit_cnt + cnt_t'(1);
            tmr_load    = 1'b1;
            tmr_val     = TIMEOUT_CYC;
          end
        end else if (tmr_expired) begin
          mismatch_d  = 1'b0;
          digit_cnt_d = '0;
          state_d     = ST_IDLE;
        end
      end
      ST_OPEN: begin
        if (tmr_expired) begin
          digit_cnt_d = '0;
          state_d     = ST_IDLE;
        end
      end
`ifdef SEQ_LOCK_LOCKOUT_EN
      ST_LOCKOUT: begin
        if (tmr_expired) begin
          fail_cnt_d = '0;
          state_d    = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Status flags are decoded from the next state and registered with it.
  always_comb begin
    unlocked_d = (state_d == ST_OPEN);
  end

`ifdef SEQ_LOCK_LOCKOUT_EN
  logic locked_out_d;

  always_comb begin
    locked_out_d = (state_d == ST_LOCKOUT);
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      locked_out <= 1'b0;
    end else begin
      locked_out <= locked_out_d;
    end
  end
`else
  // Lockout parameters have no consumer in this build; fold them into a sink.
  logic unused_lockout_cfg;
  assign unused_lockout_cfg = ^{LOCKOUT_CYC, 32'(MAX_FAIL)};
  assign locked_out = 1'b0;
`endif

endmodule

// File: tb/tb_seq_lock.sv
// Randomized self-checking bench for seq_lock against a deadline-based model
// of the lock rules; adapts to whether SEQ_LOCK_LOCKOUT_EN is defined.
module tb_seq_lock;

  localparam logic [7:0] CODE     = 8'b01_11_00_10;
  localparam int         TIMEOUT  = 100;
  localparam int         UNLOCK   = 50;
  localparam int         LOCKOUT  = 200;
  localparam int         MAX_FAIL = 3;
`ifdef SEQ_LOCK_LOCKOUT_EN
  localparam bit LOCKOUT_EN = 1'b1;
`else
  localparam bit LOCKOUT_EN = 1'b0;
`endif

  logic       sysclk = 1'b0;
  logic       reset_n;
  logic       x0, x1, x2, x3;
  logic       unlocked, error, locked_out;
  logic [2:0] digit_cnt, fail_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: absolute cycle deadlines and a queue of entered digits.
  int cyc;
  int digs[$];
  int fails;
  int open_end, lock_end, deadline;
  bit err_e;
  int err_pulses, lock_seen;

  seq_lock #(
    .CODE        (CODE),
    .TIMEOUT_CYC (24'd100),
    .UNLOCK_CYC  (24'd50),
    .LOCKOUT_CYC (24'd200),
    .MAX_FAIL    (MAX_FAIL)
  ) dut (
    .sysclk     (sysclk),
    .reset_n    (reset_n),
    .X0_deb     (x0),
    .X1_deb     (x1),
    .X2_deb     (x2),
    .X3_deb     (x3),
    .unlocked   (unlocked),
    .error      (error),
    .locked_out (locked_out),
    .digit_cnt  (digit_cnt),
    .fail_cnt   (fail_cnt)
  );

  always #5 sysclk = ~sysclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int code_digit(input int i);
    logic [7:0] c;
    c = CODE >> (2 * i);
    return int'(c[1:0]);
  endfunction

  function automatic logic [3:0] onehot(input int d);
    logic [3:0] v;
    v = 4'b0001;
    return v << d;
  endfunction

  function automatic logic [3:0] noise();
    logic [3:0] v;
    v = 4'($urandom_range(0, 15));
    if ($countones(v) == 1 || $urandom_range(0, 3) != 0) v = '0;
    return v;
  endfunction

  task automatic model_reset();
    digs.delete();
    fails    = 0;
    open_end = 0;
    lock_end = 0;
    deadline = 0;
    err_e    = 1'b0;
  endtask

  // Advance the model by one clock edge with the inputs sampled at that edge.
  task automatic model_step(input logic [3:0] x);
    int d;
    bit ok;
    cyc++;
    err_e = 1'b0;
    if (cyc - 1 < open_end) begin
      if (cyc == open_end) digs.delete();
    end else if (cyc - 1 < lock_end) begin
      if (cyc == lock_end) fails = 0;
    end else if ($countones(x) == 1) begin
      d = x[0] ? 0 : x[1] ? 1 : x[2] ? 2 : 3;
      digs.push_back(d);
      deadline = cyc + TIMEOUT;
      if (digs.size() == 4) begin
        ok = 1'b1;
        foreach (digs[i]) if (digs[i] != code_digit(i)) ok = 1'b0;
        if (ok) begin
          open_end = cyc + UNLOCK;
          fails    = 0;
        end else begin
          err_e = 1'b1;
          if (fails < 7) fails++;
          digs.delete();
          if (LOCKOUT_EN && fails >= MAX_FAIL) lock_end = cyc + LOCKOUT;
        end
      end
    end else if (digs.size() != 0 && cyc == deadline) begin
      digs.delete();
    end
  endtask

  // Drive one cycle of inputs, step the model, compare on the falling edge.
  task automatic tick(input logic [3:0] x);
    {x3, x2, x1, x0} = x;
    @(posedge sysclk);
    model_step(x);
    @(negedge sysclk);
    {x3, x2, x1, x0} = '0;
    err_pulses += int'(error);
    lock_seen  += int'(locked_out);
    check("unlocked",   32'(unlocked),   32'(cyc < open_end));
    check("locked_out", 32'(locked_out), 32'(cyc < lock_end));
    check("error",      32'(error),      32'(err_e));
    check("digit_cnt",  32'(digit_cnt),  32'(digs.size()));
    check("fail_cnt",   32'(fail_cnt),   32'(fails));
  endtask

  task automatic press(input int d, input int gap);
    tick(onehot(d));
    for (int g = 1; g < gap; g++) tick('0);
  endtask

  task automatic send_code(input int d0, input int d1, input int d2, input int d3, input int gap);
    press(d0, gap);
    press(d1, gap);
    press(d2, gap);
    tick(onehot(d3));
  endtask

  // Called on a falling edge; reset takes effect without waiting for a clock.
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("rst_unlocked",   32'(unlocked),   32'(0));
    check("rst_error",      32'(error),      32'(0));
    check("rst_locked_out", 32'(locked_out), 32'(0));
    check("rst_digit_cnt",  32'(digit_cnt),  32'(0));
    check("rst_fail_cnt",   32'(fail_cnt),   32'(0));
    model_reset();
    @(negedge sysclk);
    reset_n = 1'b1;
  endtask

  initial begin
    int cnt, e0, l0, f_exp, kind, d, gap;
    {x3, x2, x1, x0} = '0;
    reset_n    = 1'b0;
    cyc        = 0;
    err_pulses = 0;
    lock_seen  = 0;
    model_reset();
    repeat (2) @(negedge sysclk);
    check("init_unlocked",   32'(unlocked),   32'(0));
    check("init_locked_out", 32'(locked_out), 32'(0));
    check("init_digit_cnt",  32'(digit_cnt),  32'(0));
    check("init_fail_cnt",   32'(fail_cnt),   32'(0));
    reset_n = 1'b1;
    repeat (3) tick('0);

    // Correct code, presses 10 cycles apart; unlocked holds for UNLOCK cycles.
    send_code(2, 0, 3, 1, 10);
    check("open_rise", 32'(unlocked), 32'(1));
    cnt = int'(unlocked);
    repeat (69) begin
      tick('0);
      cnt += int'(unlocked);
    end
    check("open_len",  32'(cnt),       32'(UNLOCK));
    check("open_dcnt", 32'(digit_cnt), 32'(0));

    // One wrong code, then the right one clears the failure count.
    e0 = err_pulses;
    send_code(2, 0, 3, 0, 10);
    check("err_rise", 32'(error), 32'(1));
    repeat (5) tick('0);
    check("err_once",   32'(err_pulses - e0), 32'(1));
    check("fail_one",   32'(fail_cnt),        32'(1));
    check("no_open",    32'(unlocked),        32'(0));
    send_code(2, 0, 3, 1, 10);
    check("open_again", 32'(unlocked), 32'(1));
    check("fail_clear", 32'(fail_cnt), 32'(0));
    repeat (60) tick('0);

    // Three wrong codes; key presses during the lockout window are ignored.
    e0 = err_pulses;
    l0 = lock_seen;
    for (int k = 0; k < 3; k++) begin
      send_code(1, 1, 1, 1, 5);
      if (k < 2) repeat (3) tick('0);
    end
    repeat (260) begin
      if (cyc < lock_end && $urandom_range(0, 3) == 0) tick(onehot(int'($urandom_range(0, 3))));
      else tick('0);
    end
    check("lock_errs",       32'(err_pulses - e0), 32'(3));
    check("lockout_len",     32'(lock_seen - l0),  32'(LOCKOUT_EN ? LOCKOUT : 0));
    check("fail_after_lock", 32'(fail_cnt),        32'(LOCKOUT_EN ? 0 : 3));

    // Partial entry then silence: abandoned after TIMEOUT cycles, no error.
    send_code(3, 3, 3, 3, 4);
    repeat (3) tick('0);
    f_exp = fails;
    e0    = err_pulses;
    press(2, 10);
    tick(onehot(0));
    cnt = 0;
    while (digit_cnt != 3'd0 && cnt < 150) begin
      tick('0);
      cnt++;
    end
    check("timeout_len", 32'(cnt), 32'(TIMEOUT));
    repeat (150 - cnt) tick('0);
    check("timeout_fail", 32'(fail_cnt),        32'(f_exp));
    check("timeout_err",  32'(err_pulses - e0), 32'(0));

    // Chord is not a press; a press on the expiry cycle is still accepted.
    tick(4'b0110);
    check("chord_ignored", 32'(digit_cnt), 32'(0));
    press(2, TIMEOUT);
    tick(onehot(0));
    check("press_wins", 32'(digit_cnt), 32'(2));
    repeat (TIMEOUT + 5) tick('0);

    // Reset after three correct digits aborts at once.
    press(2, 3);
    press(0, 3);
    tick(onehot(3));
    check("pre_rst_dcnt", 32'(digit_cnt), 32'(3));
    do_reset();

    // Random attempts: right or random codes, random gaps, chords as noise.
    for (int t = 0; t < 50; t++) begin
      kind = int'($urandom_range(0, 2));
      for (int k = 0; k < 4; k++) begin
        d   = (kind == 0) ? code_digit(k) : int'($urandom_range(0, 3));
        gap = ($urandom_range(0, 9) == 0) ? int'($urandom_range(90, 130))
                                          : int'($urandom_range(1, 20));
        tick(onehot(d));
        for (int g = 1; g < gap; g++) tick(noise());
      end
    end

    // Reset in the middle of OPEN and in the middle of LOCKOUT.
    do_reset();
    send_code(2, 0, 3, 1, 3);
    repeat (10) tick('0);
    check("mid_open", 32'(unlocked), 32'(1));
    do_reset();
    for (int k = 0; k < 3; k++) send_code(0, 0, 0, 0, 2);
    repeat (30) tick('0);
    do_reset();
    repeat (5) tick('0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_lock.md
SEQ_LOCK -- requirements
Module: seq_lock

Interface
REQ-001 SHALL have parameter CODE, default 8'b01_11_00_10, four 2-bit digits; first digit in bits [1:0] (sequence 2,0,3,1).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 24'd10_000_000, inter-press inactivity limit in sysclk cycles.
REQ-003 SHALL have parameter UNLOCK_CYC, default 24'd5_000_000, unlocked hold time.
REQ-004 SHALL have parameter LOCKOUT_CYC, default 24'd15_000_000, lockout hold time.
REQ-005 SHALL have parameter MAX_FAIL, default 3, failed attempts that trigger lockout.
REQ-006 SHALL have port sysclk, input, 1, sole clock, rising edge.
REQ-007 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have ports X0_deb..X3_deb, input, 1 each, single-cycle debounced press pulses for digits 0..3.
REQ-009 SHALL have port unlocked, output, 1, high while in OPEN.
REQ-010 SHALL have port error, output, 1, one-cycle pulse on a wrong complete code.
REQ-011 SHALL have port locked_out, output, 1, high while in LOCKOUT.
REQ-012 SHALL have port digit_cnt, output, 3, digits accepted in the current attempt (0..4).
REQ-013 SHALL have port fail_cnt, output, 3, consecutive failed attempts.

Function
REQ-014 A press is a cycle with exactly one X*_deb high; digit = its index; zero or multiple high inputs mean no press.
REQ-015 States are IDLE, ENTRY, OPEN, LOCKOUT; all outputs are registered.
REQ-016 IDLE: a press compares the digit with CODE[1:0], sets an internal mismatch flag on inequality, sets digit_cnt=1, loads the timer with TIMEOUT_CYC, and enters ENTRY.
REQ-017 ENTRY: press k (k=2..4) compares with CODE[2k-1:2k-2], ORs the result into the mismatch flag, increments digit_cnt, and reloads the timer.
REQ-018 Evaluation on the 4th press: if there is no mismatch, go to OPEN next cycle, clear fail_cnt, and load UNLOCK_CYC.
REQ-019 Evaluation on the 4th press: if there is a mismatch, pulse error for exactly one cycle (the cycle after the press), increment fail_cnt (saturating at 7), clear digit_cnt, and go to IDLE.
REQ-020 Latency from the 4th press to unlocked or error assertion SHALL be one cycle.
REQ-021 ENTRY timeout: when the timer expires with no press, go to IDLE, set digit_cnt=0, raise no error, and leave fail_cnt unchanged.
REQ-022 A press in the same cycle the timer expires SHALL be accepted; the press wins.
REQ-023 OPEN: ignore presses; at timer expiry, clear unlocked, set digit_cnt=0, and go to IDLE.
REQ-024 LOCKOUT: ignore presses; at timer expiry, clear locked_out and fail_cnt and go to IDLE.
REQ-025 One down-counting timer (24-bit) SHALL serve all states; expiry is count==0 while armed.

Reset
REQ-026 reset_n low SHALL asynchronously force IDLE, unlocked=0, error=0, locked_out=0, digit_cnt=0, fail_cnt=0, timer disarmed, and mismatch flag cleared.
REQ-027 Reset asserted mid-entry, mid-OPEN or mid-LOCKOUT SHALL abort immediately; no error pulse.

Configuration
REQ-028 Macro SEQ_LOCK_LOCKOUT_EN defined: a failed attempt that makes fail_cnt reach MAX_FAIL goes to LOCKOUT (not IDLE), loads LOCKOUT_CYC, and sets locked_out the next cycle; the error pulse still occurs.
REQ-029 Macro SEQ_LOCK_LOCKOUT_EN undefined: the LOCKOUT state and logic are absent, locked_out is tied 0, and fail_cnt only counts and saturates.

Structure
REQ-030 Package seq_lock_pkg SHALL hold the state enumeration, the digit width constant (2), the code length (4), and the timer width (24).
REQ-031 Sub-module lock_timer (load value, load strobe, expired flag) SHALL implement the shared timer.

Verification
Bench parameters: TIMEOUT_CYC=100, UNLOCK_CYC=50, LOCKOUT_CYC=200, MAX_FAIL=3, macro defined.
REQ-032 Presses 2,0,3,1 spaced 10 cycles -> unlocked rises 1 cycle after the 4th press, stays high for 50 cycles, then IDLE with digit_cnt=0.
REQ-033 Presses 2,0,3,0 -> one-cycle error, fail_cnt=1, unlocked stays 0; then 2,0,3,1 -> unlocked and fail_cnt=0.
REQ-034 Three wrong codes -> third error pulse plus locked_out for 200 cycles; presses during lockout are ignored; afterwards fail_cnt=0.
REQ-035 Presses 2,0 then 150 idle cycles -> digit_cnt returns to 0 at cycle 100 after the last press; no error; fail_cnt unchanged.
REQ-036 X1_deb and X2_deb high together -> no digit accepted; reset_n pulsed low after 3 correct digits -> all outputs 0 immediately.
